// File: rtl/fifo_pkg.sv
// Shared constants and pointer-code helpers for the dual-clock SRAM FIFO.
// Used by both the read-side and write-side controllers.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_D = 29;
    localparam int unsigned ADDR_WIDTH_D = 7;

    // Pointers are handled zero-extended to this width so that one pair of
    // helpers serves any ADDR_WIDTH+1 pointer up to 32 bits.
    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Binary to reflected Gray code.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary; zero upper bits leave the result exact.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            b[PTR_MAX_W-1-i] = b[PTR_MAX_W-i] ^ g[PTR_MAX_W-1-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local
// clock domain. All stages are cleared by the local synchronous reset.
module ptr_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the asynchronous pointer through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock SRAM FIFO (r_clk domain only).
// Synchronises the write pointer, derives empty/rd_level, drives the SRAM
// read port and presents popped words on a registered valid/ready stream.
// Build option: define RD_SYNC3_EN for a 3-flop write-pointer synchroniser
// (default 2 flops).
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_D,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int unsigned FIFO_DEPTH = 2 ** ADDR_WIDTH
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [ADDR_WIDTH:0]   w_ptr_gray,
    output logic [ADDR_WIDTH:0]   r_ptr_gray,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_ena,
    input  logic [FIFO_WIDTH-1:0] r_data,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

`ifdef RD_SYNC3_EN
    localparam int unsigned SYNC_STAGES = 3;
`else
    localparam int unsigned SYNC_STAGES = 2;
`endif

    localparam logic EMPTY_OUT = 1'b0;
    localparam logic FULL_OUT  = 1'b1;

    if (FIFO_DEPTH != (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("fifo_rd_ctrl: FIFO_DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [PTR_W-1:0] wg_s;
    logic [PTR_W-1:0] w_bin_s;
    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_bin_nxt;
    logic             out_state;
    logic             out_state_nxt;
    logic             load;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (r_clk),
        .rst (r_rst),
        .d   (w_ptr_gray),
        .q   (wg_s)
    );

    assign w_bin_s  = PTR_W'(gray2bin(ptr_word_t'(wg_s)));
    assign empty    = (w_bin_s == r_bin);
    assign rd_level = w_bin_s - r_bin;
    assign r_addr   = r_bin[ADDR_WIDTH-1:0];
    assign m_valid  = (out_state == FULL_OUT);

    // Pop whenever SRAM holds data and the output register is free or being
    // emptied this cycle; reset suppresses the strobe.
    always_comb begin
        load      = !r_rst && !empty && (!m_valid || m_ready);
        r_ena     = load;
        r_bin_nxt = load ? r_bin + 1'b1 : r_bin;
    end

    // Output register occupancy: refill on load, drain on accept-without-load.
    always_comb begin
        out_state_nxt = out_state;
        case (out_state)
            EMPTY_OUT: if (load) out_state_nxt = FULL_OUT;
            FULL_OUT:  if (m_ready && !load) out_state_nxt = EMPTY_OUT;
            default:   out_state_nxt = EMPTY_OUT;
        endcase
    end

    // Read pointer, exported Gray pointer and output data register.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_bin      <= '0;
            r_ptr_gray <= '0;
            m_data     <= '0;
            out_state  <= EMPTY_OUT;
        end else begin
            r_bin      <= r_bin_nxt;
            r_ptr_gray <= PTR_W'(bin2gray(ptr_word_t'(r_bin_nxt)));
            out_state  <= out_state_nxt;
            if (load) begin
                m_data <= r_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl (default 2-flop build).
// A behavioural SRAM answers r_addr combinationally; the bench plays the
// write side by writing words and advancing w_ptr_gray.
module tb_fifo_rd_ctrl;

    localparam int unsigned W  = 29;
    localparam int unsigned AW = 7;
    localparam int unsigned D  = 128;

    logic          r_clk;
    logic          r_rst;
    logic [AW:0]   w_ptr_gray;
    logic [AW:0]   r_ptr_gray;
    logic [AW-1:0] r_addr;
    logic          r_ena;
    logic [W-1:0]  r_data;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          empty;
    logic [AW:0]   rd_level;

    logic [W-1:0]  mem [D];

    int unsigned n_tests;
    int unsigned n_fail;

    fifo_rd_ctrl #(
        .FIFO_WIDTH (W),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (D)
    ) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .w_ptr_gray (w_ptr_gray),
        .r_ptr_gray (r_ptr_gray),
        .r_addr     (r_addr),
        .r_ena      (r_ena),
        .r_data     (r_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .empty      (empty),
        .rd_level   (rd_level)
    );

    assign r_data = mem[r_addr];

    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    function automatic logic [AW:0] gray(input int unsigned b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W-1:0] stream_word(input int unsigned k);
        logic [31:0] v;
        v = (k * 32'h9E37_79B1) ^ 32'h0000_0015;
        return v[W-1:0];
    endfunction

    task automatic do_reset();
        r_rst      = 1'b1;
        w_ptr_gray = '0;
        m_ready    = 1'b0;
        tick();
        tick();
        r_rst = 1'b0;
    endtask

    int unsigned written;
    int unsigned acc;
    int unsigned cyc;
    int unsigned idx;
    logic [AW:0]   prev_gray;
    logic [AW-1:0] prev_addr;
    logic          saw_addr_wrap;
    logic          saw_bin_wrap;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < int'(D); i++) mem[i] = '0;

        // 1. Reset state
        do_reset();
        check("rst_m_valid",  m_valid,    1'b0);
        check("rst_empty",    empty,      1'b1);
        check("rst_r_addr",   r_addr,     7'd0);
        check("rst_r_ptr",    r_ptr_gray, 8'd0);
        check("rst_rd_level", rd_level,   8'd0);
        check("rst_r_ena",    r_ena,      1'b0);
        check("rst_m_data",   m_data,     29'd0);

        // 2. Single word, 3-edge latency
        mem[0]     = 29'h0ABCDEF;
        m_ready    = 1'b1;
        w_ptr_gray = gray(1);
        tick();
        check("sw_e1_valid", m_valid, 1'b0);
        check("sw_e1_ena",   r_ena,   1'b0);
        check("sw_e1_empty", empty,   1'b1);
        tick();
        check("sw_e2_valid", m_valid,  1'b0);
        check("sw_e2_ena",   r_ena,    1'b1);
        check("sw_e2_level", rd_level, 8'd1);
        tick();
        check("sw_e3_valid", m_valid,    1'b1);
        check("sw_e3_data",  m_data,     29'h0ABCDEF);
        check("sw_e3_ena",   r_ena,      1'b0);
        check("sw_e3_addr",  r_addr,     7'd1);
        check("sw_e3_ptr",   r_ptr_gray, 8'd1);
        check("sw_e3_empty", empty,      1'b1);
        tick();
        check("sw_e4_valid", m_valid, 1'b0);
        check("sw_e4_data",  m_data,  29'h0ABCDEF);

        // 3. Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 29'h1110000 + 29'(i);
        w_ptr_gray = gray(4);
        tick();
        tick();
        check("bp_level4", rd_level, 8'd4);
        check("bp_ena1",   r_ena,    1'b1);
        tick();
        check("bp_valid", m_valid,  1'b1);
        check("bp_data0", m_data,   29'h1110000);
        check("bp_level", rd_level, 8'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data",  m_data,   29'h1110000);
            check("bp_hold_valid", m_valid,  1'b1);
            check("bp_hold_ena",   r_ena,    1'b0);
            check("bp_hold_level", rd_level, 8'd3);
        end
        m_ready = 1'b1;
        #1;
        check("bp_ready_ena", r_ena, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("bp_next_valid", m_valid, 1'b1);
            check("bp_next_data",  m_data,  29'h1110000 + 29'(i));
        end
        check("bp_empty", empty, 1'b1);
        tick();
        check("bp_drop_valid", m_valid, 1'b0);

        // 4. Long stream with wrap and random backpressure (r_bin now 4)
        written       = 4;
        acc           = 4;
        cyc           = 0;
        prev_gray     = r_ptr_gray;
        prev_addr     = r_addr;
        saw_addr_wrap = 1'b0;
        saw_bin_wrap  = 1'b0;
        m_ready       = 1'b0;
        while (acc < 304 && cyc < 5000) begin
            tick();
            cyc++;
            if ($countones(prev_gray ^ r_ptr_gray) > 1)
                check("wr_gray_step", r_ptr_gray, prev_gray);
            if (prev_addr == 7'd127 && r_addr == 7'd0) saw_addr_wrap = 1'b1;
            if (prev_gray == 8'h80 && r_ptr_gray == 8'h00) saw_bin_wrap = 1'b1;
            prev_gray = r_ptr_gray;
            prev_addr = r_addr;
            m_ready = ($urandom_range(0, 3) != 0);
            if (written < 304 && (written - acc) < D && $urandom_range(0, 4) != 0) begin
                mem[written % D] = stream_word(written);
                written++;
                w_ptr_gray = gray(written);
            end
            if (m_valid && m_ready) begin
                check("wr_data", m_data, stream_word(acc));
                acc++;
            end
        end
        check("wr_done",      acc,           304);
        check("wr_addr_wrap", saw_addr_wrap, 1'b1);
        check("wr_bin_wrap",  saw_bin_wrap,  1'b1);
        m_ready = 1'b1;
        tick();
        tick();
        check("wr_end_empty", empty,   1'b1);
        check("wr_end_valid", m_valid, 1'b0);

        // 5. Full FIFO
        do_reset();
        for (int i = 0; i < int'(D); i++) mem[i] = 29'h1000000 | 29'(i);
        w_ptr_gray = 8'hC0;
        tick();
        tick();
        check("full_empty", empty,    1'b0);
        check("full_level", rd_level, 8'd128);
        m_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < D && cyc < 400) begin
            tick();
            cyc++;
            if (m_valid) begin
                check("full_drain", m_data, 29'h1000000 | 29'(idx));
                idx++;
            end
        end
        check("full_count", idx, D);
        check("full_end_empty", empty,    1'b1);
        check("full_end_level", rd_level, 8'd0);

        // 6. Reset mid-stream
        do_reset();
        for (int i = 0; i < 6; i++) mem[i] = 29'h0555000 + 29'(i);
        w_ptr_gray = gray(6);
        tick();
        tick();
        tick();
        check("mr_valid", m_valid,  1'b1);
        check("mr_level", rd_level, 8'd5);
        r_rst = 1'b1;
        #1;
        check("mr_ena_in_rst", r_ena, 1'b0);
        tick();
        check("mr_valid_after", m_valid,    1'b0);
        check("mr_ptr_after",   r_ptr_gray, 8'd0);
        check("mr_data_after",  m_data,     29'd0);
        check("mr_ena_after",   r_ena,      1'b0);
        r_rst      = 1'b0;
        w_ptr_gray = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock SRAM FIFO, running entirely in the read clock domain.
- Synchronises the write pointer and computes empty and read-side occupancy.
- Drives the SRAM read port (r_addr, r_ena) and exports the Gray read pointer back to the write side.
- Presents popped words on a registered valid/ready output stream.

Parameters:
FIFO_WIDTH, 29, data word width; must match the SRAM width.
FIFO_DEPTH, 128, number of SRAM entries; must equal 2**ADDR_WIDTH.
ADDR_WIDTH, 7, SRAM address width; pointers are ADDR_WIDTH+1 bits.

Ports:
r_clk  input  1  read-domain clock; the only clock in this block.
r_rst  input  1  synchronous, active-high reset in the r_clk domain.
w_ptr_gray  input  ADDR_WIDTH+1  Gray-coded write pointer from the write domain; asynchronous to r_clk.
r_ptr_gray  output  ADDR_WIDTH+1  registered Gray-coded read pointer, sent to the write-side full logic.
r_addr  output  ADDR_WIDTH  SRAM read address.
r_ena  output  1  one-cycle strobe per word popped from the SRAM.
r_data  input  FIFO_WIDTH  SRAM read data, combinational from r_addr.
m_data  output  FIFO_WIDTH  output word.
m_valid  output  1  m_data is valid.
m_ready  input  1  consumer accepts m_data this cycle.
empty  output  1  no unread entries remain in the SRAM.
rd_level  output  ADDR_WIDTH+1  unread SRAM entries as seen from the read side, range 0..FIFO_DEPTH.

Behaviour:
Reset:
- Only r_rst high at a rising r_clk edge resets the block.
- Reset clears all synchroniser flops, r_bin and r_ptr_gray to 0, m_valid to 0 and m_data to 0.
- Combinationally after reset: r_addr=0, r_ena=0, empty=1, rd_level=0.
- Reset mid-stream discards any word held in m_data with no handshake. The system must reset the write side in the same window.

Pointer synchronisation:
- w_ptr_gray passes through a 2-flop synchroniser to give wg_s, then is converted Gray-to-binary to give w_bin_s.
- w_ptr_gray is sampled with no reset-free assumptions; the synchroniser flops are reset like all other state.

Read pointer and status:
- r_bin is the binary read pointer, ADDR_WIDTH+1 bits.
- r_addr = r_bin[ADDR_WIDTH-1:0].
- r_ptr_gray is registered as bin2gray(next r_bin), so it changes at most one bit per cycle.
- empty = (w_bin_s == r_bin).
- rd_level = w_bin_s - r_bin, modulo 2**(ADDR_WIDTH+1). It counts SRAM entries only and excludes a word held in m_data.

Pop condition:
- load = !empty && (!m_valid || m_ready).
- r_ena = load, combinational and high for exactly the cycles in which a pop occurs.
- On load, at the next edge: m_data <= r_data at the current r_addr, r_bin <= r_bin+1, and m_valid <= 1.
- Else if m_valid && m_ready: m_valid <= 0 and m_data holds its value.
- Else all state holds.
- m_data and m_valid never change while m_valid=1 and m_ready=0.

Output state machine, two states:
- EMPTY_OUT (m_valid=0) moves to FULL_OUT on load.
- FULL_OUT (m_valid=1) stays in FULL_OUT on load while accepting (the output register is refilled in the same cycle).
- FULL_OUT moves to EMPTY_OUT when accepted without load.

Throughput and latency:
- Throughput is 1 word per cycle while the FIFO is non-empty and m_ready=1.
- A w_ptr_gray change reaches m_valid=1 on the 3rd r_clk edge after it is first sampled: 2 synchroniser edges plus 1 output edge.

Wrap and full:
- Pointers wrap naturally: r_bin goes 2**(ADDR_WIDTH+1)-1 -> 0, and r_addr goes FIFO_DEPTH-1 -> 0.
- A full FIFO (w_bin_s - r_bin == FIFO_DEPTH) gives empty=0 and rd_level=FIFO_DEPTH.

Simultaneous events:
- r_rst dominates load and accept in the same cycle.

Optional Feature:
Macro: RD_SYNC3_EN
- Defined: the w_ptr_gray synchroniser is 3 flops. Write-to-m_valid latency becomes 4 edges, and empty/rd_level lag one extra cycle.
- Undefined: 2-flop synchroniser as described above.
- All other behaviour is identical in both builds.

Decomposition:
Package fifo_pkg:
- Default constants FIFO_WIDTH_D=29, ADDR_WIDTH_D=7.
- Functions bin2gray and gray2bin, parameterised on ADDR_WIDTH+1 bits.
- Shared with the write-side controller.

Sub-module ptr_sync:
- Parameterised width and stage count, reset flop chain.
- Instantiated once for w_ptr_gray.
- The stage count is chosen by RD_SYNC3_EN.

Test Plan:
1. Reset: hold r_rst=1 for 2 cycles with w_ptr_gray=0 -> m_valid=0, empty=1, r_addr=0, r_ptr_gray=0, rd_level=0, r_ena=0.
2. Single word: with MEM[0]=29'h0ABCDEF, step w_ptr_gray 0->1 and hold m_ready=1 -> on the 3rd edge m_valid=1 and m_data=29'h0ABCDEF. Also check a one-cycle r_ena, r_addr=1, r_ptr_gray=1 and empty=1.
3. Backpressure: 4 words at addresses 0..3 with m_ready=0 -> exactly one pop, m_data stable, rd_level=3. Then set m_ready=1 -> words 1,2,3 follow on consecutive cycles and m_valid drops after the 4th accept.
4. Wrap: stream 300 sequential words, advancing w_ptr_gray by bin2gray one step at a time, with random m_ready -> output order matches input, r_addr wraps 127->0, r_bin wraps 255->0, and r_ptr_gray changes ≤1 bit per cycle.
5. Full: with r_bin=0, set w_ptr_gray=bin2gray(128) -> after sync, empty=0, rd_level=128, and draining yields MEM[0..127] in order.
6. Reset mid-stream: with m_valid=1, m_ready=0 and rd_level=5, pulse r_rst for 1 cycle -> next cycle m_valid=0, r_ptr_gray=0, and no r_ena while r_rst=1.
